// File: rtl/if_fetch_stage.sv
// if_fetch_stage: holds the PC, fetches instruction words over a req/ack handshake
// and presents them to decode through an IF/ID register backed by a one-entry skid buffer.
// Optional build macro IF_MISALIGN_TRAP_EN: misaligned redirect targets raise o_misalign
// and halt fetching until an aligned redirect arrives. Without it the target's low bits
// are cleared.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [6:0]  o_opcode,
    output logic [31:0] o_pc
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic        o_misalign
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;          // address of the next fetch to launch
    logic [31:0] addr_q, addr_d;      // address presented on the memory port
    logic        kill_q, kill_d;      // outstanding fetch is wrong-path
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        halt_d;
    logic [31:0] redirect_tgt;

`ifdef IF_MISALIGN_TRAP_EN
    logic        misalign_q, misalign_d;
    assign redirect_tgt = i_redirect_pc;
    assign o_misalign   = misalign_q;
`else
    assign redirect_tgt = i_redirect_pc & 32'hFFFF_FFFC;
`endif

    logic req_active;
    logic ack_hit;
    logic req_pending;
    logic fetch_done;

    assign req_active  = (state_q == S_REQ);
    assign ack_hit     = req_active & i_imem_ack;
    assign req_pending = req_active & ~i_imem_ack;
    // A completion only delivers data when it belongs to the current path.
    assign fetch_done  = ack_hit & ~kill_q & ~i_redirect;

    assign o_imem_req  = req_active;
    assign o_imem_addr = addr_q;
    assign o_valid     = out_valid_q;
    assign o_instr     = out_instr_q;
    assign o_opcode    = out_instr_q[6:0];
    assign o_pc        = out_pc_q;

    // Next-state logic: PC, kill tracking, output register/skid steering and FSM.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        kill_d       = kill_q;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        halt_d       = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
        misalign_d   = misalign_q;
`endif

        if (i_redirect) begin
            // Redirect wins over stall: flush everything held and restart at the target.
            pc_d         = redirect_tgt;
            out_valid_d  = 1'b0;
            out_instr_d  = NOP_INSTR;
            skid_valid_d = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
            misalign_d   = |i_redirect_pc[1:0];
`endif
        end else begin
            if (ack_hit && !kill_q) begin
                pc_d = pc_q + 32'd4;
            end
            if (!out_valid_q || !i_stall) begin
                // Output register is free or advancing: skid first, then a fresh completion.
                if (skid_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_instr_d  = skid_instr_q;
                    out_pc_d     = skid_pc_q;
                    skid_valid_d = fetch_done;
                    if (fetch_done) begin
                        skid_instr_d = i_imem_rdata;
                        skid_pc_d    = addr_q;
                    end
                end else if (fetch_done) begin
                    out_valid_d = 1'b1;
                    out_instr_d = i_imem_rdata;
                    out_pc_d    = addr_q;
                end else begin
                    out_valid_d = 1'b0;
                    out_instr_d = NOP_INSTR;
                end
            end else if (fetch_done) begin
                // Decode is stalled on a valid instruction: park the arrival in the skid.
                skid_valid_d = 1'b1;
                skid_instr_d = i_imem_rdata;
                skid_pc_d    = addr_q;
            end
        end

        // A request that has not been acked keeps its address; a redirect marks it wrong-path.
        kill_d = req_pending & (i_redirect | kill_q);
        addr_d = req_pending ? addr_q : pc_d;

`ifdef IF_MISALIGN_TRAP_EN
        halt_d = misalign_d;
`endif

        // The skid absorbs one arrival during a stall, so keep requesting while it will be empty.
        if (req_pending) begin
            state_d = S_REQ;
        end else if (halt_d) begin
            state_d = S_IDLE;
        end else if (skid_valid_d) begin
            state_d = S_HOLD;
        end else begin
            state_d = S_REQ;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            kill_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_instr_q  <= NOP_INSTR;
            out_pc_q     <= RESET_PC;
            skid_valid_q <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= RESET_PC;
`ifdef IF_MISALIGN_TRAP_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            kill_q       <= kill_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
`ifdef IF_MISALIGN_TRAP_EN
            misalign_q   <= misalign_d;
`endif
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed and randomized checks of the fetch stage against an
// in-order PC stream model and an address-derived instruction memory.
`timescale 1ns/1ps
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic        valid;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [31:0] pc;
`ifdef IF_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int checks    = 0;
    int failures  = 0;
    int delivered = 0;
    int mem_delay = 0;   // <0 selects a random 0..3 wait per request

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_stall      (stall),
        .i_redirect   (redirect),
        .i_redirect_pc(redirect_pc),
        .o_imem_req   (req),
        .o_imem_addr  (addr),
        .i_imem_ack   (ack),
        .i_imem_rdata (rdata),
        .o_valid      (valid),
        .o_instr      (instr),
        .o_opcode     (opcode),
        .o_pc         (pc)
`ifdef IF_MISALIGN_TRAP_EN
        ,
        .o_misalign   (misalign)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Instruction memory: answers a request after mem_delay wait cycles.
    initial begin : memory
        int cnt;
        int cur;
        cnt = 0;
        cur = 0;
        ack = 1'b0;
        rdata = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (rst || !req) begin
                ack = 1'b0;
                rdata = $urandom;
                cnt = 0;
            end else begin
                if (cnt == 0) cur = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
                if (cnt >= cur) begin
                    ack = 1'b1;
                    rdata = mem_word(addr);
                    cnt = 0;
                end else begin
                    ack = 1'b0;
                    rdata = $urandom;
                    cnt++;
                end
            end
        end
    end

    // Reference model: decode must see PCs in program order, restarted by each redirect.
    initial begin : monitor
        logic [31:0] exp_pc, p_addr, p_pc, p_instr;
        logic        p_pend, p_hold, p_redir;
        exp_pc = RESET_PC;
        p_addr = 32'h0; p_pc = 32'h0; p_instr = 32'h0;
        p_pend = 1'b0; p_hold = 1'b0; p_redir = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                exp_pc = RESET_PC;
                p_pend = 1'b0; p_hold = 1'b0; p_redir = 1'b0;
            end else begin
                if (p_pend) begin
                    checks++;
                    if (req !== 1'b1 || addr !== p_addr) begin
                        failures++;
                        $display("FAIL req_hold: req=%0b addr=%h, required req=1 addr=%h", req, addr, p_addr);
                    end
                end
                if (p_hold) begin
                    checks++;
                    if (valid !== 1'b1 || pc !== p_pc || instr !== p_instr) begin
                        failures++;
                        $display("FAIL stall_freeze: valid=%0b pc=%h instr=%h, required 1 %h %h", valid, pc, instr, p_pc, p_instr);
                    end
                end
                if (p_redir) begin
                    checks++;
                    if (valid !== 1'b0) begin
                        failures++;
                        $display("FAIL redirect_flush: valid=%0b, required 0", valid);
                    end
                end
                checks++;
                if (opcode !== instr[6:0]) begin
                    failures++;
                    $display("FAIL opcode: opcode=%h, required %h", opcode, instr[6:0]);
                end
                if (valid !== 1'b1) begin
                    checks++;
                    if (instr !== NOP) begin
                        failures++;
                        $display("FAIL nop_fill: instr=%h, required %h", instr, NOP);
                    end
                end
                if (valid === 1'b1 && stall === 1'b0) begin
                    checks++;
                    delivered++;
                    $display("deliver pc=%h instr=%h", pc, instr);
                    if (pc !== exp_pc || instr !== mem_word(exp_pc)) begin
                        failures++;
                        $display("FAIL stream: pc=%h instr=%h, required pc=%h instr=%h", pc, instr, exp_pc, mem_word(exp_pc));
                        exp_pc = pc;
                    end
                    exp_pc = exp_pc + 32'd4;
                end
                if (redirect === 1'b1) begin
`ifdef IF_MISALIGN_TRAP_EN
                    exp_pc = redirect_pc;
`else
                    exp_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
                end
                p_pend  = req && !ack;
                p_addr  = addr;
                p_hold  = valid && stall && !redirect;
                p_pc    = pc;
                p_instr = instr;
                p_redir = redirect;
            end
        end
    end

    // Reset then release on a falling edge; returns just after the release.
    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        #4;
        checks++; if (req !== 1'b0) begin failures++; $display("FAIL reset_req: %0b, required 0", req); end
        checks++; if (addr !== RESET_PC) begin failures++; $display("FAIL reset_addr: %h, required %h", addr, RESET_PC); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: %0b, required 0", valid); end
        checks++; if (instr !== NOP) begin failures++; $display("FAIL reset_instr: %h, required %h", instr, NOP); end
        checks++; if (opcode !== 7'b0010011) begin failures++; $display("FAIL reset_opcode: %h, required 13", opcode); end
        checks++; if (pc !== RESET_PC) begin failures++; $display("FAIL reset_pc: %h, required %h", pc, RESET_PC); end
`ifdef IF_MISALIGN_TRAP_EN
        checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign: %0b, required 0", misalign); end
`endif
        @(negedge clk);
    endtask

    task automatic test_zero_wait();
        logic [31:0] e;
        mem_delay = 0;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            #4;
            if (k == 0) begin
                checks++; if (req !== 1'b0) begin failures++; $display("FAIL zw_idle_req: %0b, required 0", req); end
            end else if (k == 1) begin
                checks++; if (req !== 1'b1 || addr !== RESET_PC) begin failures++; $display("FAIL zw_first_req: req=%0b addr=%h, required 1 %h", req, addr, RESET_PC); end
                checks++; if (valid !== 1'b0) begin failures++; $display("FAIL zw_early_valid: %0b, required 0", valid); end
            end else begin
                e = RESET_PC + 32'(4 * (k - 2));
                checks++;
                if (valid !== 1'b1 || pc !== e || instr !== mem_word(e) || opcode !== instr[6:0]) begin
                    failures++;
                    $display("FAIL zw_stream: valid=%0b pc=%h instr=%h, required 1 %h %h", valid, pc, instr, e, mem_word(e));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wait2();
        int vc[$];
        mem_delay = 2;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            #4;
            if (valid === 1'b1) vc.push_back(c);
            @(negedge clk);
        end
        checks++;
        if (vc.size() != 4) begin failures++; $display("FAIL w2_count: %0d valid cycles, required 4", vc.size()); end
        for (int i = 0; i < vc.size(); i++) begin
            checks++;
            if (vc[i] != 4 + 3 * i) begin failures++; $display("FAIL w2_spacing: valid in cycle %0d, required %0d", vc[i], 4 + 3 * i); end
        end
    endtask

    task automatic test_stall();
        int guard;
        int acks;
        mem_delay = 0;
        do_reset();
        guard = 0;
        while (!(valid === 1'b1 && pc === 32'h8) && guard < 20) begin @(negedge clk); guard++; end
        checks++;
        if (guard >= 20) begin failures++; $display("FAIL stall_reach: pc=%h, required 8 within 20 cycles", pc); end
        stall = 1'b1;
        acks = 0;
        for (int s = 0; s < 4; s++) begin
            #4;
            checks++;
            if (valid !== 1'b1 || pc !== 32'h8) begin failures++; $display("FAIL stall_hold: valid=%0b pc=%h, required 1 8", valid, pc); end
            if (req === 1'b1 && ack === 1'b1) acks++;
            if (s >= 1) begin
                checks++;
                if (req !== 1'b0) begin failures++; $display("FAIL stall_skid_req: req=%0b, required 0", req); end
            end
            @(negedge clk);
        end
        checks++;
        if (acks != 1) begin failures++; $display("FAIL stall_acks: %0d completions, required 1", acks); end
        stall = 1'b0;
        #4;
        @(negedge clk);
        #4;
        checks++;
        if (valid !== 1'b1 || pc !== 32'hC) begin failures++; $display("FAIL stall_rel1: valid=%0b pc=%h, required 1 c", valid, pc); end
        @(negedge clk);
        #4;
        checks++;
        if (valid !== 1'b1 || pc !== 32'h10) begin failures++; $display("FAIL stall_rel2: valid=%0b pc=%h, required 1 10", valid, pc); end
        @(negedge clk);
    endtask

    task automatic test_redirect_pending();
        int guard;
        logic got;
        mem_delay = 3;
        do_reset();
        guard = 0;
        while (!(req === 1'b1 && addr === 32'h10) && guard < 80) begin @(negedge clk); guard++; end
        checks++;
        if (guard >= 80) begin failures++; $display("FAIL rp_reach: addr=%h, required 10 within 80 cycles", addr); end
        redirect = 1'b1;
        redirect_pc = 32'h0000_0100;
        #4;
        checks++;
        if (req !== 1'b1 || addr !== 32'h10 || ack !== 1'b0) begin failures++; $display("FAIL rp_start: req=%0b addr=%h ack=%0b, required 1 10 0", req, addr, ack); end
        @(negedge clk);
        redirect = 1'b0;
        guard = 0;
        got = 1'b0;
        while (!got && guard < 10) begin
            #4;
            checks++;
            if (req !== 1'b1 || addr !== 32'h10) begin failures++; $display("FAIL rp_kill_hold: req=%0b addr=%h, required 1 10", req, addr); end
            if (ack === 1'b1) got = 1'b1;
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!got) begin failures++; $display("FAIL rp_ack_timeout: no ack, required one within 10 cycles"); end
        #4;
        checks++;
        if (req !== 1'b1 || addr !== 32'h100) begin failures++; $display("FAIL rp_new_addr: req=%0b addr=%h, required 1 100", req, addr); end
        guard = 0;
        while (valid !== 1'b1 && guard < 20) begin @(negedge clk); #4; guard++; end
        checks++;
        if (valid !== 1'b1 || pc !== 32'h100) begin failures++; $display("FAIL rp_first_valid: valid=%0b pc=%h, required 1 100", valid, pc); end
        @(negedge clk);
    endtask

    task automatic test_redirect_stall();
        int guard;
        mem_delay = 0;
        do_reset();
        guard = 0;
        while (valid !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
        stall = 1'b1;
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        #4;
        checks++;
        if (req !== 1'b0) begin failures++; $display("FAIL rs_skid_req: req=%0b, required 0", req); end
        @(negedge clk);
        redirect = 1'b0;
        stall = 1'b0;
        #4;
        checks++;
        if (valid !== 1'b0 || instr !== NOP) begin failures++; $display("FAIL rs_flush: valid=%0b instr=%h, required 0 %h", valid, instr, NOP); end
        checks++;
        if (req !== 1'b1 || addr !== 32'h200) begin failures++; $display("FAIL rs_resume: req=%0b addr=%h, required 1 200", req, addr); end
        @(negedge clk);
        #4;
        checks++;
        if (valid !== 1'b1 || pc !== 32'h200 || instr !== mem_word(32'h200)) begin failures++; $display("FAIL rs_first: valid=%0b pc=%h instr=%h, required 1 200 %h", valid, pc, instr, mem_word(32'h200)); end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int guard;
        logic seen_fc;
        logic done;
        mem_delay = 1;
        do_reset();
        repeat (3) @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        @(negedge clk);
        redirect = 1'b0;
        seen_fc = 1'b0;
        done = 1'b0;
        guard = 0;
        while (!done && guard < 40) begin
            #4;
            if (req === 1'b1 && ack === 1'b1) begin
                if (seen_fc) begin
                    done = 1'b1;
                    checks++;
                    if (addr !== 32'h0) begin failures++; $display("FAIL wrap_addr: %h, required 00000000", addr); end
                end else if (addr === 32'hFFFF_FFFC) begin
                    seen_fc = 1'b1;
                end
            end
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!done) begin failures++; $display("FAIL wrap_timeout: wrapped fetch not seen, required within 40 cycles"); end
        repeat (4) @(negedge clk);
    endtask

`ifdef IF_MISALIGN_TRAP_EN
    task automatic test_misalign();
        mem_delay = 0;
        do_reset();
        repeat (4) @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0102;
        @(negedge clk);
        redirect = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #4;
            checks++;
            if (misalign !== 1'b1 || req !== 1'b0 || valid !== 1'b0) begin failures++; $display("FAIL mis_halt: misalign=%0b req=%0b valid=%0b, required 1 0 0", misalign, req, valid); end
            @(negedge clk);
        end
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        redirect = 1'b0;
        #4;
        checks++;
        if (misalign !== 1'b0 || req !== 1'b1 || addr !== 32'h200) begin failures++; $display("FAIL mis_resume: misalign=%0b req=%0b addr=%h, required 0 1 200", misalign, req, addr); end
        @(negedge clk);
        #4;
        checks++;
        if (valid !== 1'b1 || pc !== 32'h200) begin failures++; $display("FAIL mis_first: valid=%0b pc=%h, required 1 200", valid, pc); end
        @(negedge clk);
    endtask
`else
    task automatic test_mask();
        mem_delay = 0;
        do_reset();
        repeat (3) @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0106;
        @(negedge clk);
        redirect = 1'b0;
        #4;
        checks++;
        if (req !== 1'b1 || addr !== 32'h104) begin failures++; $display("FAIL mask_addr: req=%0b addr=%h, required 1 104", req, addr); end
        @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid();
        mem_delay = 3;
        do_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (req !== 1'b1) begin failures++; $display("FAIL rm_pending: req=%0b, required 1", req); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (req !== 1'b0 || addr !== RESET_PC) begin failures++; $display("FAIL rm_req: req=%0b addr=%h, required 0 %h", req, addr, RESET_PC); end
        checks++;
        if (valid !== 1'b0 || pc !== RESET_PC || instr !== NOP) begin failures++; $display("FAIL rm_out: valid=%0b pc=%h instr=%h, required 0 %h %h", valid, pc, instr, RESET_PC, NOP); end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_random();
        int d0;
        mem_delay = -1;
        do_reset();
        d0 = delivered;
        for (int i = 0; i < 1500; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 29) == 0);
`ifdef IF_MISALIGN_TRAP_EN
            redirect_pc = $urandom & 32'hFFFF_FFFC;
`else
            redirect_pc = $urandom;
`endif
            @(negedge clk);
        end
        stall = 1'b0;
        redirect = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (delivered - d0 < 100) begin failures++; $display("FAIL rand_progress: %0d delivered, required at least 100", delivered - d0); end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        test_reset();
        test_zero_wait();
        test_wait2();
        test_stall();
        test_redirect_pending();
        test_redirect_stall();
        test_wrap();
`ifdef IF_MISALIGN_TRAP_EN
        test_misalign();
`else
        test_mask();
`endif
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
